// File: rtl/prio_seg_pkg.sv
// Shared constants for the priority-encoder segment display.
// Active-low 7-segment patterns, bit6=a .. bit0=g.
package prio_seg_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'b00,
        MODE_STICKY = 2'b01,
        MODE_FREEZE = 2'b10
    } mode_e;

    localparam logic [6:0] SEG_ZERO = 7'b0000001;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low 7-segment pattern.
// Purely combinational lookup.
module hex_to_seg7
    import prio_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/prio_enc_seg_disp.sv
// Registered priority encoder with hex 7-segment readout,
// sticky-max / freeze modes and a saturating change counter.
module prio_enc_seg_disp
    import prio_seg_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int DIGITS = 2,
    parameter  int CNT_W  = 8,
    localparam int IDX_W  = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WIDTH-1:0]    sw,
    input  logic [1:0]          mode,
    input  logic                clr,
    output logic                valid,
    output logic [IDX_W-1:0]    idx,
    output logic [WIDTH-1:0]    led,
    output logic [7*DIGITS-1:0] seg,
    output logic [CNT_W-1:0]    chg_cnt
);

    if (4*DIGITS < IDX_W) begin : g_digits_check
        $error("DIGITS too small to show the index");
    end

    logic [WIDTH-1:0] sw_q;
    logic [IDX_W-1:0] nidx;
    logic             nvalid;
    logic             load;
    logic             chg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q <= '0;
        end else if (en) begin
            sw_q <= sw;
        end
    end

    assign led = en ? sw_q : '0;

    // Ascending scan: the last set bit seen is the highest.
    always_comb begin
        nidx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sw_q[i]) nidx = IDX_W'(i);
        end
    end

    assign nvalid = |sw_q;

    always_comb begin
        load = 1'b0;
        if (en && !clr) begin
            unique case (mode)
                MODE_LIVE:   load = 1'b1;
                MODE_STICKY: load = nvalid && (!valid || nidx > idx);
                default:     load = 1'b0;
            endcase
        end
    end

    assign chg = load && ({nvalid, nidx} != {valid, idx});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            valid   <= 1'b0;
            chg_cnt <= '0;
        end else if (clr) begin
            idx     <= '0;
            valid   <= 1'b0;
            chg_cnt <= '0;
        end else begin
            if (load) begin
                idx   <= nidx;
                valid <= nvalid;
            end
            if (chg && chg_cnt != {CNT_W{1'b1}}) begin
                chg_cnt <= chg_cnt + CNT_W'(1);
            end
        end
    end

    logic [4*DIGITS-1:0] disp_val;
    logic [6:0]          hex_seg [DIGITS];
    logic                show;

    assign disp_val = (4*DIGITS)'(idx);
    assign show     = en && valid;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        hex_to_seg7 u_hex (
            .nib (disp_val[4*k +: 4]),
            .seg (hex_seg[k])
        );
        assign seg[7*k +: 7] = show ? hex_seg[k] : SEG_ZERO;
    end

endmodule

// File: tb/tb_prio_enc_seg_disp.sv
// Directed table-driven bench for prio_enc_seg_disp.
// A second instance with CNT_W=2 checks counter saturation.
module tb_prio_enc_seg_disp;

    localparam logic [6:0] Z  = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SB = 7'b1100000;
    localparam logic [6:0] SF = 7'b0111000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] sw;
    logic [1:0]  mode;
    logic        clr;
    logic        valid, valid2;
    logic [3:0]  idx, idx2;
    logic [15:0] led, led2;
    logic [13:0] seg, seg2;
    logic [7:0]  chg_cnt;
    logic [1:0]  chg_cnt2;

    int errors = 0;
    int checks = 0;

    prio_enc_seg_disp #(.WIDTH(16), .DIGITS(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sw(sw), .mode(mode),
        .clr(clr), .valid(valid), .idx(idx), .led(led),
        .seg(seg), .chg_cnt(chg_cnt)
    );

    prio_enc_seg_disp #(.WIDTH(16), .DIGITS(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .sw(sw), .mode(mode),
        .clr(clr), .valid(valid2), .idx(idx2), .led(led2),
        .seg(seg2), .chg_cnt(chg_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] sw;
        logic        en;
        logic [1:0]  mode;
        logic        clr;
        logic [3:0]  idx;
        logic        valid;
        logic [15:0] led;
        logic [7:0]  cnt;
        logic [13:0] seg;
    } vec_t;

    vec_t v [30];

    task automatic chk(input string name, input int n,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h",
                     name, n, act, exp);
        end
    endtask

    task automatic chk_all(input int n, input logic [3:0] e_idx,
                           input logic e_valid, input logic [15:0] e_led,
                           input logic [7:0] e_cnt, input logic [13:0] e_seg);
        logic [1:0] e_cnt2;
        e_cnt2 = (e_cnt > 8'd3) ? 2'd3 : e_cnt[1:0];
        chk("idx", n, 32'(idx), 32'(e_idx));
        chk("valid", n, 32'(valid), 32'(e_valid));
        chk("led", n, 32'(led), 32'(e_led));
        chk("chg_cnt", n, 32'(chg_cnt), 32'(e_cnt));
        chk("seg", n, 32'(seg), 32'(e_seg));
        chk("chg_cnt_sat", n, 32'(chg_cnt2), 32'(e_cnt2));
    endtask

    initial begin
        // sw, en, mode, clr | idx, valid, led, cnt, seg
        v[0]  = '{16'h0900, 1, 2'd0, 0, 4'd0,  0, 16'h0900, 8'd0, {Z, Z}};
        v[1]  = '{16'h0900, 1, 2'd0, 0, 4'd11, 1, 16'h0900, 8'd1, {Z, SB}};
        v[2]  = '{16'h0001, 1, 2'd0, 0, 4'd11, 1, 16'h0001, 8'd1, {Z, SB}};
        v[3]  = '{16'h0001, 1, 2'd0, 0, 4'd0,  1, 16'h0001, 8'd2, {Z, Z}};
        v[4]  = '{16'h0000, 1, 2'd0, 0, 4'd0,  1, 16'h0000, 8'd2, {Z, Z}};
        v[5]  = '{16'h0000, 1, 2'd0, 0, 4'd0,  0, 16'h0000, 8'd3, {Z, Z}};
        v[6]  = '{16'h0010, 1, 2'd1, 0, 4'd0,  0, 16'h0010, 8'd3, {Z, Z}};
        v[7]  = '{16'h0100, 1, 2'd1, 0, 4'd4,  1, 16'h0100, 8'd4, {Z, S4}};
        v[8]  = '{16'h0004, 1, 2'd1, 0, 4'd8,  1, 16'h0004, 8'd5, {Z, S8}};
        v[9]  = '{16'h0000, 1, 2'd1, 0, 4'd8,  1, 16'h0000, 8'd5, {Z, S8}};
        v[10] = '{16'h0000, 1, 2'd1, 0, 4'd8,  1, 16'h0000, 8'd5, {Z, S8}};
        v[11] = '{16'h0000, 1, 2'd1, 1, 4'd0,  0, 16'h0000, 8'd0, {Z, Z}};
        v[12] = '{16'h8000, 1, 2'd0, 0, 4'd0,  0, 16'h8000, 8'd0, {Z, Z}};
        v[13] = '{16'h8000, 1, 2'd0, 0, 4'd15, 1, 16'h8000, 8'd1, {Z, SF}};
        v[14] = '{16'h0002, 1, 2'd2, 0, 4'd15, 1, 16'h0002, 8'd1, {Z, SF}};
        v[15] = '{16'h0002, 1, 2'd2, 0, 4'd15, 1, 16'h0002, 8'd1, {Z, SF}};
        v[16] = '{16'h0002, 1, 2'd3, 0, 4'd15, 1, 16'h0002, 8'd1, {Z, SF}};
        v[17] = '{16'h0004, 0, 2'd0, 0, 4'd15, 1, 16'h0000, 8'd1, {Z, Z}};
        v[18] = '{16'h0004, 0, 2'd0, 0, 4'd15, 1, 16'h0000, 8'd1, {Z, Z}};
        v[19] = '{16'h0002, 1, 2'd0, 0, 4'd1,  1, 16'h0002, 8'd2, {Z, S1}};
        v[20] = '{16'h0002, 1, 2'd0, 0, 4'd1,  1, 16'h0002, 8'd2, {Z, S1}};
        v[21] = '{16'h0002, 0, 2'd0, 1, 4'd0,  0, 16'h0000, 8'd0, {Z, Z}};
        v[22] = '{16'h0001, 1, 2'd0, 0, 4'd1,  1, 16'h0001, 8'd1, {Z, S1}};
        v[23] = '{16'h0002, 1, 2'd0, 0, 4'd0,  1, 16'h0002, 8'd2, {Z, Z}};
        v[24] = '{16'h0001, 1, 2'd0, 0, 4'd1,  1, 16'h0001, 8'd3, {Z, S1}};
        v[25] = '{16'h0002, 1, 2'd0, 0, 4'd0,  1, 16'h0002, 8'd4, {Z, Z}};
        v[26] = '{16'h0001, 1, 2'd0, 0, 4'd1,  1, 16'h0001, 8'd5, {Z, S1}};
        v[27] = '{16'h0002, 1, 2'd0, 0, 4'd0,  1, 16'h0002, 8'd6, {Z, Z}};
        v[28] = '{16'h0001, 1, 2'd0, 1, 4'd0,  0, 16'h0001, 8'd0, {Z, Z}};
        v[29] = '{16'h0001, 1, 2'd0, 0, 4'd0,  1, 16'h0001, 8'd1, {Z, Z}};

        rst  = 1'b0;
        en   = 1'b1;
        sw   = 16'hFFFF;
        mode = 2'd0;
        clr  = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all(-1, 4'd0, 1'b0, 16'h0000, 8'd0, {Z, Z});
        @(posedge clk); #1;
        chk_all(-2, 4'd0, 1'b0, 16'h0000, 8'd0, {Z, Z});
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            sw   = v[i].sw;
            en   = v[i].en;
            mode = v[i].mode;
            clr  = v[i].clr;
            @(posedge clk); #1;
            chk_all(i, v[i].idx, v[i].valid, v[i].led,
                    v[i].cnt, v[i].seg);
        end

        // Async reset between edges, then synchronous-in-effect release.
        #3 rst = 1'b1;
        #1;
        chk_all(100, 4'd0, 1'b0, 16'h0000, 8'd0, {Z, Z});
        @(posedge clk); #1;
        chk_all(101, 4'd0, 1'b0, 16'h0000, 8'd0, {Z, Z});
        rst = 1'b0;
        sw  = 16'h0001;
        en  = 1'b1;
        clr = 1'b0;
        @(posedge clk); #1;
        chk_all(102, 4'd0, 1'b0, 16'h0001, 8'd0, {Z, Z});
        @(posedge clk); #1;
        chk_all(103, 4'd0, 1'b1, 16'h0001, 8'd1, {Z, Z});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
